dmem_lsu: RTL

Load/store initiator that sits between the core's execute stage and the word-addressed `mem` data memory (synchronous write, asynchronous read). It accepts one byte/halfword/word request at a time over a valid/ready handshake and translates byte addresses to word indices. It performs read-modify-write for sub-word stores, sign- or zero-extends loads, and flags misaligned or illegal-size accesses without touching memory.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/dmem_lsu_if.sv | 23 ++
 rtl/lsu_align.sv | 42 ++++
 rtl/dmem_lsu.sv | 112 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the dmem_lsu load/store initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  // Alignment check only; the illegal size is handled separately by the caller.
  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response handshake of the dmem_lsu.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: little-endian load extract with sign/zero extension and
// sub-word store merge into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rd_word[{off, 3'b000} +: 8];
    lane_h    = off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_H:    load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    merge_data = old_word;
    case (size)
      SZ_B: merge_data[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (off[1]) merge_data[31:16] = wdata[15:0];
        else        merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator: one request at a time, read-modify-write for sub-word
// stores, error response for misaligned or illegal-size accesses.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_lsu_if.slave        bus,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_addr_pt,
  output logic [31:0]      mem_wr_data,
  input  logic [31:0]      mem_rd_data
);

  lsu_state_e       state_q;
  logic             we_q;
  logic             uns_q;
  size_e            size_q;
  logic [WIDTH+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      old_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  size_e            req_size;
  logic             req_err;
  logic [31:0]      load_data;
  logic [31:0]      merge_data;

  // Byte address bits above the word index wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:WIDTH+2];

  always_comb begin
    req_size = size_e'(bus.req_size);
    req_err  = (req_size == SZ_ILL) || misaligned(req_size, bus.req_addr[1:0]);
  end

  lsu_align u_align (
    .rd_word     (mem_rd_data),
    .old_word    (old_q),
    .wdata       (wdata_q),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= req_size;
            addr_q  <= bus.req_addr[WIDTH+1:0];
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err)                             state_q <= RESP;
            else if (bus.req_we && req_size == SZ_W) state_q <= WRITE;
            else                                     state_q <= READ;
          end
        end
        READ: begin
          old_q <= mem_rd_data;
          if (we_q) begin
            state_q <= WRITE;
          end else begin
            rdata_q <= load_data;
            state_q <= RESP;
          end
        end
        WRITE:   state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every output is held at zero while reset is asserted, even mid-access.
  always_comb begin
    bus.req_ready  = rst_n && (state_q == IDLE);
    bus.resp_valid = rst_n && (state_q == RESP);
    bus.resp_rdata = rst_n ? rdata_q : '0;
    bus.resp_err   = rst_n && err_q;
    mem_wr_en      = rst_n && (state_q == WRITE);
    mem_addr_pt    = '0;
    mem_wr_data    = '0;
    if (rst_n && (state_q == READ || state_q == WRITE)) begin
      mem_addr_pt = addr_q[WIDTH+1:2];
    end
    if (rst_n && state_q == WRITE) begin
      mem_wr_data = (size_q == SZ_W) ? wdata_q : merge_data;
    end
  end

endmodule
